i2s_rx_ctrl: RTL and testbench
==============================

Name: i2s_rx_ctrl

Overview:
- Controller that sequences an i2s_receiver instance and turns its mono sample stream into stereo frames.
- Gates the receiver enable and discards a configurable number of warm-up frames after start.
- Pairs left/right words using lrclk, buffers complete frames in a small FIFO, and hands them downstream over a valid/ready interface.
- Sits between the i2s_receiver and the audio DSP/DMA consumer; reports overflow and channel-desync errors.

Parameters:
- WORD_LEN, 24, audio word width in bits (matches receiver audio_data_o).
- FIFO_DEPTH, 4, stereo frames buffered; power of two, >= 2.
- WARMUP_FRAMES, 2, complete L/R pairs discarded after each start; 0 = none.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle pulse: begin capture.
- stop_i  in  1  single-cycle pulse: end capture at next frame boundary.
- lrclk_i  in  1  word-select from clock_generator.
- new_sample_i  in  1  receiver new_sample_o (one-cycle pulse).
- sample_i  in  WORD_LEN  receiver audio_data_o.
- rx_enable_o  out  1  drives receiver/clock_generator enable_i.
- busy_o  out  1  high when state != IDLE.
- frame_valid_o  out  1  FIFO not empty.
- frame_ready_i  in  1  consumer accepts frame.
- left_o  out  WORD_LEN  left word of FIFO head.
- right_o  out  WORD_LEN  right word of FIFO head.
- overflow_o  out  1  sticky: a completed frame was dropped because the FIFO was full.
- sync_err_o  out  1  sticky: two left words arrived without an intervening right.
- clr_err_i  in  1  clears both sticky flags.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; FIFO empty; left holding register empty.
  - Reset mid-operation discards everything immediately.
- Channel tag:
  - At a new_sample_i pulse, lrclk_i==1 means the completed word is LEFT; lrclk_i==0 means RIGHT.
  - new_sample_i is ignored in IDLE.
- Pairing:
  - LEFT loads the holding register and sets hold_valid.
  - If hold_valid is already set: overwrite the register and set sync_err_o.
  - RIGHT with hold_valid completes the pair {hold,sample_i} and clears hold_valid.
  - RIGHT without hold_valid is discarded silently.
- FSM states: IDLE, WARMUP, RUN, DRAIN.
  - IDLE -> WARMUP on start_i (WARMUP_FRAMES>0), else IDLE -> RUN. The transition clears hold_valid and the warm-up counter.
  - WARMUP: each completed pair is discarded and increments the counter. When the counter reaches WARMUP_FRAMES -> RUN. stop_i -> IDLE.
  - RUN: each completed pair is pushed. On stop_i: -> DRAIN if hold_valid, else -> IDLE.
  - DRAIN: the next completed pair is pushed, then -> IDLE. A further LEFT is handled per the pairing rules.
  - start_i and stop_i in the same cycle: stop wins. start_i outside IDLE is ignored.
- rx_enable_o: registered; 1 in WARMUP/RUN/DRAIN. It rises the cycle after start_i and falls the cycle after entering IDLE.
- Latency: the RIGHT pulse in cycle N gives a frame visible on frame_valid_o/left_o/right_o in cycle N+1.
- FIFO:
  - A pop occurs on frame_valid_o & frame_ready_i.
  - Push when full with a simultaneous pop succeeds.
  - Push when full without a pop drops the new frame and sets overflow_o; the head and stored frames are unchanged.
  - Outputs are stable while valid & !ready.
  - The FIFO is not flushed by stop_i or start_i; only rst_i clears it.
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap-around. full = MSB differs and rest equal.
- Sticky flags: clr_err_i clears both flags. A set event in the same cycle as clr_err_i wins, so the flag reads 1.

Decomposition:
- Shared package i2s_pkg:
  - typedef enum rx_ctrl_state_e {IDLE,WARMUP,RUN,DRAIN}.
  - Parameterised-width struct/typedef stereo_frame_t {left,right}.
  - Constant I2S_DEFAULT_WORD_LEN=24.
- One sub-module i2s_frame_fifo: synchronous FIFO with params WIDTH and DEPTH, push/pop/full/empty, head data output. It is reusable by the transmitter side.

Test Plan:
- Reset: assert rst_i mid-clock -> all outputs 0 asynchronously; new_sample_i pulses while IDLE -> no frame, rx_enable_o=0.
- Warm-up: start_i, then pairs (0x20F3FF,0x20F3FB) x2 discarded. Third pair L=0x20F3F7, R=0x20F3FF -> frame_valid_o=1 one cycle after the R pulse, with left_o=0x20F3F7 and right_o=0x20F3FF.
- Backpressure/overflow: in RUN with frame_ready_i=0, send 5 pairs (L=i, R=0x100+i, i=1..5) -> 4 frames held, overflow_o=1. Raise ready -> pops in order i=1..4. clr_err_i -> overflow_o=0.
- Desync: LEFT 0x111111, LEFT 0x222222, RIGHT 0x333333 -> one frame {0x222222,0x333333}, sync_err_o=1. RIGHT without a preceding LEFT -> no frame.
- Stop mid-frame: stop_i after LEFT 0xABCDEF -> DRAIN, rx_enable_o stays 1. RIGHT 0x123456 -> frame pushed, IDLE, rx_enable_o=0 the next cycle. Simultaneous start_i+stop_i in RUN -> goes to IDLE.
- Full push+pop: FIFO full, ready=1 in the same cycle as the RIGHT pulse -> no overflow, count stays 4, new frame at the tail.

Source files
------------

// File: rtl/i2s_rx_ctrl_pkg.sv
// Shared I2S receive-side types: controller states and the stereo frame layout.
package i2s_pkg;

  localparam int I2S_DEFAULT_WORD_LEN = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } rx_ctrl_state_e;

  // Default-width frame; modules with a different word length declare
  // the same layout locally from their WORD_LEN parameter.
  typedef struct packed {
    logic [I2S_DEFAULT_WORD_LEN-1:0] left;
    logic [I2S_DEFAULT_WORD_LEN-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO; a push into a full FIFO lands only if the same
// cycle pops. Head output reads 0 while empty.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// Sequences an i2s_receiver: gates its enable, drops warm-up frames, pairs
// left/right words into stereo frames and queues them for a valid/ready consumer.
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int WORD_LEN      = I2S_DEFAULT_WORD_LEN,
  parameter int FIFO_DEPTH    = 4,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                lrclk_i,
  input  logic                new_sample_i,
  input  logic [WORD_LEN-1:0] sample_i,
  output logic                rx_enable_o,
  output logic                busy_o,
  output logic                frame_valid_o,
  input  logic                frame_ready_i,
  output logic [WORD_LEN-1:0] left_o,
  output logic [WORD_LEN-1:0] right_o,
  output logic                overflow_o,
  output logic                sync_err_o,
  input  logic                clr_err_i
);

  // Handshake: a frame transfers on any cycle where frame_valid_o and
  // frame_ready_i are both high; head data holds steady while valid && !ready.

  typedef struct packed {
    logic [WORD_LEN-1:0] left;
    logic [WORD_LEN-1:0] right;
  } frame_t;

  localparam int CW = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;

  rx_ctrl_state_e      state, state_nx;
  logic [WORD_LEN-1:0] hold;
  logic                hold_valid, hold_valid_nx;
  logic [CW-1:0]       warm_cnt, warm_cnt_nx;
  logic                is_left, is_right, pair_done, start_go;
  logic                push, fifo_full, fifo_empty;
  logic                sync_set, ovf_set;
  frame_t              push_frame, head_frame;

  always_comb begin
    is_left       = 1'b0;
    is_right      = 1'b0;
    pair_done     = 1'b0;
    hold_valid_nx = hold_valid;
    if (state != IDLE && new_sample_i) begin
      is_left  = lrclk_i;
      is_right = ~lrclk_i;
    end
    pair_done = is_right & hold_valid;
    if (is_left)        hold_valid_nx = 1'b1;
    else if (pair_done) hold_valid_nx = 1'b0;
  end

  always_comb begin
    state_nx    = state;
    warm_cnt_nx = warm_cnt;
    push        = 1'b0;
    start_go    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !stop_i) begin
          start_go = 1'b1;
          state_nx = (WARMUP_FRAMES > 0) ? WARMUP : RUN;
        end
      end
      WARMUP: begin
        if (stop_i) begin
          state_nx = IDLE;
        end else if (pair_done) begin
          warm_cnt_nx = warm_cnt + CW'(1);
          if (warm_cnt_nx == CW'(WARMUP_FRAMES)) state_nx = RUN;
        end
      end
      RUN: begin
        push = pair_done;
        // A left word still waiting for its right keeps us alive to finish the frame.
        if (stop_i) state_nx = hold_valid_nx ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (pair_done) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (start_go) warm_cnt_nx = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rx_enable_o <= 1'b0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      warm_cnt    <= '0;
    end else begin
      state       <= state_nx;
      rx_enable_o <= (state_nx != IDLE);
      warm_cnt    <= warm_cnt_nx;
      hold_valid  <= start_go ? 1'b0 : hold_valid_nx;
      if (is_left) hold <= sample_i;
    end
  end

  assign sync_set = is_left & hold_valid;
  assign ovf_set  = push & fifo_full & ~frame_ready_i;

  // Set beats clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      sync_err_o <= sync_set | (sync_err_o & ~clr_err_i);
      overflow_o <= ovf_set | (overflow_o & ~clr_err_i);
    end
  end

  assign push_frame.left  = hold;
  assign push_frame.right = sample_i;

  i2s_frame_fifo #(
    .WIDTH($bits(frame_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (push_frame),
    .pop_i  (frame_ready_i),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head_frame)
  );

  assign busy_o        = (state != IDLE);
  assign frame_valid_o = ~fifo_empty;
  assign left_o        = head_frame.left;
  assign right_o       = head_frame.right;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: directed scenarios plus random traffic, all checked
// against a frame-queue model of the controller.
module tb_i2s_rx_ctrl;

  localparam int W     = 24;
  localparam int DEPTH = 4;
  localparam int WARM  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0, stop_i = 1'b0, lrclk_i = 1'b0, new_sample_i = 1'b0;
  logic [W-1:0] sample_i = '0;
  logic         frame_ready_i = 1'b0, clr_err_i = 1'b0;
  logic         rx_enable_o, busy_o, frame_valid_o, overflow_o, sync_err_o;
  logic [W-1:0] left_o, right_o;

  int checks = 0;
  int failures = 0;

  i2s_rx_ctrl #(.WORD_LEN(W), .FIFO_DEPTH(DEPTH), .WARMUP_FRAMES(WARM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i),
    .lrclk_i(lrclk_i), .new_sample_i(new_sample_i), .sample_i(sample_i),
    .rx_enable_o(rx_enable_o), .busy_o(busy_o), .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i), .left_o(left_o), .right_o(right_o),
    .overflow_o(overflow_o), .sync_err_o(sync_err_o), .clr_err_i(clr_err_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [2*W-1:0] exp_q[$];
  bit             m_cap, m_drain, m_hv, m_ovf, m_sync;
  int             m_skip;
  logic [W-1:0]   m_hold;

  task automatic deliver(input logic [2*W-1:0] f);
    if (exp_q.size() < DEPTH) exp_q.push_back(f);
    else m_ovf = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cap = 0; m_drain = 0; m_hv = 0; m_skip = 0; m_hold = '0;
      m_ovf = 0; m_sync = 0;
      exp_q.delete();
    end else begin
      bit got, do_pop;
      logic [2*W-1:0] frame;
      got = 0;
      frame = '0;
      do_pop = (exp_q.size() > 0) && frame_ready_i;
      if (clr_err_i) begin m_ovf = 0; m_sync = 0; end
      if (m_cap && new_sample_i) begin
        if (lrclk_i) begin
          if (m_hv) m_sync = 1;
          m_hold = sample_i;
          m_hv = 1;
        end else if (m_hv) begin
          frame = {m_hold, sample_i};
          m_hv = 0;
          got = 1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (!m_cap) begin
        if (start_i && !stop_i) begin m_cap = 1; m_skip = WARM; m_hv = 0; end
      end else if (m_drain) begin
        if (got) begin deliver(frame); m_cap = 0; m_drain = 0; end
      end else if (m_skip > 0) begin
        if (stop_i) m_cap = 0;
        else if (got) m_skip--;
      end else begin
        if (got) deliver(frame);
        if (stop_i) begin
          if (m_hv) m_drain = 1;
          else m_cap = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2*W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("frame_valid", frame_valid_o, (exp_q.size() > 0));
    chk("left", left_o, head[2*W-1:W]);
    chk("right", right_o, head[W-1:0]);
    chk("rx_enable", rx_enable_o, m_cap);
    chk("busy", busy_o, m_cap);
    chk("overflow", overflow_o, m_ovf);
    chk("sync_err", sync_err_o, m_sync);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input bit lr, input logic [W-1:0] d);
    lrclk_i = lr; sample_i = d; new_sample_i = 1'b1;
    tick();
    new_sample_i = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    send_word(1'b1, l);
    send_word(1'b0, r);
  endtask

  task automatic pulse(input bit s, input bit p, input bit c);
    start_i = s; stop_i = p; clr_err_i = c;
    tick();
    start_i = 1'b0; stop_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic start_run();
    pulse(1, 0, 0);
    for (int i = 0; i < WARM; i++) send_pair(24'h0F0F0F, 24'h0E0E0E);
  endtask

  task automatic drain_fifo();
    frame_ready_i = 1'b1;
    idle(DEPTH + 1);
    frame_ready_i = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", frame_valid_o, 1'b0);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_en", rx_enable_o, 1'b0);
    chk("async_rst_left", left_o, '0);
    chk("async_rst_ovf", overflow_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(3);
    rst = 1'b0;
    tick();
    chk("reset_valid", frame_valid_o, 1'b0);
    chk("reset_en", rx_enable_o, 1'b0);

    // samples while idle are ignored
    send_pair(24'h123123, 24'h456456);
    tick();
    chk("idle_no_frame", frame_valid_o, 1'b0);
    chk("idle_no_en", rx_enable_o, 1'b0);

    // warm-up: two pairs dropped, third delivered one cycle after its right word
    pulse(1, 0, 0);
    chk("start_en", rx_enable_o, 1'b1);
    send_pair(24'h20F3FF, 24'h20F3FB);
    send_pair(24'h20F3FF, 24'h20F3FB);
    chk("warm_discard", frame_valid_o, 1'b0);
    send_pair(24'h20F3F7, 24'h20F3FF);
    chk("warm_valid", frame_valid_o, 1'b1);
    chk("warm_left", left_o, 24'h20F3F7);
    chk("warm_right", right_o, 24'h20F3FF);
    chk("model_warm_head", exp_q[0], 48'h20F3F7_20F3FF);
    drain_fifo();

    // backpressure and overflow
    for (int i = 1; i <= 5; i++) send_pair(W'(i), W'(32'h100 + i));
    chk("bp_overflow", overflow_o, 1'b1);
    chk("model_bp_size", exp_q.size(), DEPTH);
    frame_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_pop_left", left_o, W'(i));
      chk("bp_pop_right", right_o, W'(32'h100 + i));
      tick();
    end
    frame_ready_i = 1'b0;
    chk("bp_empty", frame_valid_o, 1'b0);
    pulse(0, 0, 1);
    chk("bp_clr", overflow_o, 1'b0);

    // mid-operation reset with frames queued
    send_pair(24'h0000AA, 24'h0000BB);
    send_word(1'b1, 24'h0000CC);
    async_reset();

    // desync
    start_run();
    send_word(1'b1, 24'h111111);
    send_word(1'b1, 24'h222222);
    send_word(1'b0, 24'h333333);
    chk("desync_err", sync_err_o, 1'b1);
    chk("desync_left", left_o, 24'h222222);
    chk("desync_right", right_o, 24'h333333);
    send_word(1'b0, 24'h444444);
    tick();
    chk("orphan_right_size", exp_q.size(), 1);
    chk("orphan_right_head", right_o, 24'h333333);
    drain_fifo();
    pulse(0, 0, 1);

    // full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) send_pair(W'(32'hA0 + i), W'(32'h1A0 + i));
    send_word(1'b1, 24'h0000A5);
    frame_ready_i = 1'b1;
    send_word(1'b0, 24'h0001A5);
    frame_ready_i = 1'b0;
    chk("full_pp_ovf", overflow_o, 1'b0);
    chk("full_pp_head", left_o, 24'h0000A2);
    chk("model_full_pp_tail", exp_q[DEPTH-1], 48'h0000A5_0001A5);
    drain_fifo();

    // stop mid-frame goes through DRAIN
    send_word(1'b1, 24'hABCDEF);
    pulse(0, 1, 0);
    chk("drain_busy", busy_o, 1'b1);
    chk("drain_en", rx_enable_o, 1'b1);
    send_word(1'b0, 24'h123456);
    chk("drain_done_en", rx_enable_o, 1'b0);
    chk("drain_left", left_o, 24'hABCDEF);
    chk("drain_right", right_o, 24'h123456);
    drain_fifo();

    // start+stop together: stop wins
    pulse(1, 1, 0);
    chk("idle_startstop", busy_o, 1'b0);
    start_run();
    chk("run_busy", busy_o, 1'b1);
    pulse(1, 1, 0);
    chk("run_startstop", busy_o, 1'b0);

    // random traffic
    begin
      bit lr;
      lr = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        frame_ready_i = ($urandom_range(0, 2) != 0);
        start_i       = ($urandom_range(0, 19) == 0);
        stop_i        = ($urandom_range(0, 79) == 0);
        clr_err_i     = ($urandom_range(0, 49) == 0);
        new_sample_i  = ($urandom_range(0, 2) == 0);
        if (new_sample_i) begin
          if ($urandom_range(0, 99) < 88) lr = ~lr;
          lrclk_i  = lr;
          sample_i = W'($urandom);
        end
        if (c % 8 == 0) frame_ready_i = frame_ready_i & ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 999) == 0) async_reset();
        else tick();
      end
      start_i = 0; stop_i = 0; clr_err_i = 0; new_sample_i = 0; frame_ready_i = 0;
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
